// File: rtl/syscon_shutdown.sv
// System-controller slave: firmware writes a magic command, the block flushes
// the trace/file logic, then holds a sticky shutdown or reboot indication.
module syscon_shutdown #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_sel,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  input  logic              i_file_closed,
  output logic              o_close_file,
  output logic              o_shutdown,
  output logic              o_reboot,
  output logic [15:0]       o_exit_code
);

  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned CNT_W = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;
  localparam logic [1:0] REBOOT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             kind_q, kind_d;       // 1 = reboot requested
  logic [15:0]      code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      scratch_q;

  logic [WA_W-1:0]  word_c;
  logic             wr_c, rd_c;
  logic             cmd_valid_c, cmd_reboot_c;
  logic [15:0]      cmd_code_c;
  logic [1:0]       target_c;
  logic [31:0]      rdata_c;
  logic             unused_addr;

  assign word_c      = i_addr[ADDR_W-1:2];
  assign unused_addr = ^i_addr[1:0];
  assign wr_c        = i_stb & i_we;
  assign rd_c        = i_stb & ~i_we;
  assign target_c    = kind_q ? REBOOT : HALT;

  // Magic-word decode; only full-word writes to CMD count.
  always_comb begin
    cmd_valid_c  = 1'b0;
    cmd_reboot_c = 1'b0;
    cmd_code_c   = 16'h0000;
    if (wr_c && (word_c == WA_W'(0)) && (i_sel == 4'b1111)) begin
      unique case (i_wdata[15:0])
        16'h5555: cmd_valid_c = 1'b1;
        16'h3333: begin
          cmd_valid_c = 1'b1;
          cmd_code_c  = (i_wdata[31:16] == 16'h0000) ? 16'h0001 : i_wdata[31:16];
        end
        16'h7777: begin
          cmd_valid_c  = 1'b1;
          cmd_reboot_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; later commands are ignored once out of IDLE.
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_c) begin
          kind_d = cmd_reboot_c;
          code_d = cmd_code_c;
          if (FLUSH_TIMEOUT == 0) begin
            state_d = cmd_reboot_c ? REBOOT : HALT;
          end else begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_TIMEOUT);
          end
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (i_file_closed) begin
          state_d = target_c;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d   = target_c;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State register; sideband outputs are registered copies of the next state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      kind_q       <= 1'b0;
      code_q       <= 16'h0000;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      o_close_file <= 1'b0;
      o_shutdown   <= 1'b0;
      o_reboot     <= 1'b0;
      o_exit_code  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
      o_close_file <= (state_d == FLUSH);
      o_shutdown   <= (state_d == HALT);
      o_reboot     <= (state_d == REBOOT);
      o_exit_code  <= (state_d == HALT) ? code_d : 16'h0000;
    end
  end

  // Read mux uses current-state values, so a read racing a transition sees the old STATUS.
  // Busy covers the flush phase; terminal states report through their own bits.
  always_comb begin
    rdata_c = 32'h0000_0000;
    case (word_c)
      WA_W'(1): rdata_c = {code_q, 12'h000, timeout_q, (state_q == REBOOT),
                           (state_q == HALT), (state_q == FLUSH)};
      WA_W'(2): rdata_c = scratch_q;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ack   <= 1'b0;
      o_rdata <= 32'h0000_0000;
    end else begin
      o_ack   <= i_stb;
      o_rdata <= rd_c ? rdata_c : 32'h0000_0000;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scratch_q <= 32'h0000_0000;
    end else if (wr_c && (word_c == WA_W'(2))) begin
      for (int b = 0; b < 4; b++) begin
        if (i_sel[b]) scratch_q[8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_syscon_shutdown.sv
// Directed bench for syscon_shutdown: bus read data goes through a scoreboard
// queue, sideband outputs are checked inline by the stimulus thread.
module tb_syscon_shutdown;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic        ack;
  logic [31:0] rdata;
  logic        file_closed = 1'b0;
  logic        close_file;
  logic        shutdown;
  logic        reboot;
  logic [15:0] exit_code;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  syscon_shutdown #(.ADDR_W(4), .FLUSH_TIMEOUT(8)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_stb        (stb),
    .i_we         (we),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .i_sel        (sel),
    .o_ack        (ack),
    .o_rdata      (rdata),
    .i_file_closed(file_closed),
    .o_close_file (close_file),
    .o_shutdown   (shutdown),
    .o_reboot     (reboot),
    .o_exit_code  (exit_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ack_unexpected: got ack with rdata %h, expected no ack", rdata);
      end else begin
        chk("bus_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // One bus access; returns at posedge+1 of the cycle where o_ack is high.
  task automatic access(input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rd);
    stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    exp_q.push_back(w ? 32'h0 : exp_rd);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; wdata = 32'h0; sel = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    access(1'b1, a, d, s, 32'h0);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp_rd);
    access(1'b0, a, 32'h0, 4'hF, exp_rd);
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_ack"},   {31'h0, ack}, 32'h0);
    chk({tag, "_rst_rdata"}, rdata, 32'h0);
    chk({tag, "_rst_side"},  {28'h0, close_file, shutdown, reboot, 1'b0}, 32'h0);
    chk({tag, "_rst_code"},  {16'h0, exit_code}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    int n;
    // Reset state and SCRATCH clearing
    do_reset("init");
    wr(4'h8, 32'hDEADBEEF, 4'hF);
    rd(4'h8, 32'hDEADBEEF);
    rd(4'h4, 32'h0);
    do_reset("scr");
    rd(4'h8, 32'h0);

    // Pass command, file closes three cycles after close request
    wr(4'h0, 32'h0000_5555, 4'hF);
    chk("pass_close_rise", {31'h0, close_file}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pass_close_hold", {30'h0, close_file, shutdown}, 32'h2);
    end
    file_closed = 1'b1;
    cyc();
    chk("pass_close_drop", {31'h0, close_file}, 32'h0);
    chk("pass_shutdown", {30'h0, shutdown, reboot}, 32'h2);
    chk("pass_code", {16'h0, exit_code}, 32'h0);
    file_closed = 1'b0;
    rd(4'h4, 32'h0000_0002);

    // Fail command with timeout after exactly 8 cycles
    do_reset("tmo");
    wr(4'h0, 32'h002A_3333, 4'hF);
    n = 0;
    rd(4'h4, 32'h002A_0001);
    n = 1;
    while (shutdown !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("tmo_cycles", n, 8);
    chk("tmo_code", {16'h0, exit_code}, 32'h002A);
    chk("tmo_close_drop", {31'h0, close_file}, 32'h0);
    rd(4'h4, 32'h002A_000A);
    wr(4'h0, 32'h0000_7777, 4'hF);
    cyc();
    chk("halt_ignores_cmd", {30'h0, shutdown, reboot}, 32'h2);

    // Fail code 0 reported as 1
    do_reset("code1");
    file_closed = 1'b1;
    wr(4'h0, 32'h0000_3333, 4'hF);
    cyc();
    chk("code1_shutdown", {31'h0, shutdown}, 32'h1);
    chk("code1_code", {16'h0, exit_code}, 32'h0001);
    file_closed = 1'b0;

    // Partial byte-enable command has no effect
    do_reset("part");
    wr(4'h0, 32'h0000_7777, 4'b0011);
    chk("part_idle", {29'h0, close_file, shutdown, reboot}, 32'h0);
    rd(4'h4, 32'h0);

    // Reboot wins over a later pass command issued during FLUSH
    do_reset("rbt");
    wr(4'h0, 32'h0000_7777, 4'hF);
    wr(4'h0, 32'h0000_5555, 4'hF);
    chk("rbt_flush", {31'h0, close_file}, 32'h1);
    file_closed = 1'b1;
    cyc();
    chk("rbt_reboot", {29'h0, close_file, shutdown, reboot}, 32'h1);
    chk("rbt_code", {16'h0, exit_code}, 32'h0);
    file_closed = 1'b0;
    rd(4'h4, 32'h0000_0004);
    wr(4'h8, 32'h00AB_0000, 4'b0100);
    rd(4'h8, 32'h00AB_0000);
    wr(4'hC, 32'h1234_5678, 4'hF);
    rd(4'hC, 32'h0);
    rd(4'h0, 32'h0);

    // Reset in the middle of FLUSH, then a clean pass
    do_reset("mid");
    wr(4'h0, 32'h0000_5555, 4'hF);
    chk("mid_flush", {31'h0, close_file}, 32'h1);
    do_reset("mid2");
    rd(4'h4, 32'h0);
    file_closed = 1'b1;
    wr(4'h0, 32'h0000_5555, 4'hF);
    cyc();
    chk("mid_after_shutdown", {30'h0, close_file, shutdown}, 32'h1);
    file_closed = 1'b0;

    cyc();
    cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
